dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two requesters: port 0 is the core data path (load/store stage) and port 1 is the UART program loader / DMA engine.
- Issues at most one memory access per cycle and returns read data with a fixed 1-cycle latency to whichever port issued the read.
- Sits between the core's memory stage, the loader and the memory wrapper.
- Drives the core stall input whenever port 0 is denied.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/arb_rr2.sv | 27 ++
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : arbiter FSM state (round-robin or port-1 burst)
//   owner_e     : which port owns the read data returning next cycle
//   WE_READ     : byte-enable value that marks a read access
package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_STATE_RR     = 1'b0,
        ARB_STATE_BURST1 = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_P0   = 2'd1,
        OWNER_P1   = 2'd2
    } owner_e;

    localparam logic [3:0] WE_READ = 4'b0000;

    function automatic logic is_read(input logic [3:0] we);
        return we == WE_READ;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker.
// Ports:
//   req[1:0]      : request from port 1 (bit 1) and port 0 (bit 0)
//   last          : port granted most recently (the other one wins a tie)
//   prio_override : when set and port 1 requests, port 1 wins outright
//   gnt[1:0]      : one-hot (or zero) grant
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_override,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (prio_override && req[1]) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port synchronous memory between the
// core load/store path (port 0) and the loader/DMA engine (port 1).
// One access per cycle, read data returned one cycle after the grant.
// Port 1 may hold the memory for bursts of up to MAX_BURST accesses with p1_lock.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   p0_req/we/addr/wdata          : port 0 request (we == 0 means read)
//   p0_gnt, p0_rvalid, p0_rdata   : port 0 grant and read return
//   p1_req/we/addr/wdata, p1_lock : port 1 request, burst lock
//   p1_gnt, p1_rvalid, p1_rdata   : port 1 grant and read return
//   mem_en/we/addr/din, mem_dout  : memory interface
//   stall                         : port 0 requesting but not granted
//
// Build option: define CORE_PRIORITY_EN for fixed priority to port 0 with a
// starvation guard that force-grants port 1 after MAX_WAIT denied cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AWIDTH    = 14,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [3:0]        p0_we,
    input  logic [AWIDTH-1:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DWIDTH-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic [3:0]        p1_we,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DWIDTH-1:0] p1_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              stall
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       last_q, last_d;     // 1: port 1 granted most recently
    logic [7:0] burst_q, burst_d;
    logic [7:0] burst_inc;

    logic [1:0] pick;
    logic       rr_last;
    logic       override;
    logic       burst_hold;

    assign burst_hold = (state_q == ARB_STATE_BURST1) && p1_req && p1_lock;
    assign burst_inc  = burst_q + 8'd1;

`ifdef CORE_PRIORITY_EN
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [7:0] wait_q, wait_d;

    // Tie always resolves to port 0; the wait counter breaks starvation.
    assign rr_last  = 1'b1;
    assign override = (wait_q == WAIT_LIM);

    always_comb begin
        wait_d = 8'd0;
        if (p1_req && !p1_gnt) begin
            wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_max_wait;

    assign rr_last         = last_q;
    assign override        = 1'b0;
    assign unused_max_wait = ^8'(MAX_WAIT);
`endif

    arb_rr2 u_rr (
        .req           ({p1_req, p0_req}),
        .last          (rr_last),
        .prio_override (override),
        .gnt           (pick)
    );

    // Grants are forced low during reset so nothing reaches the memory.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (burst_hold) begin
                p1_gnt = 1'b1;
            end else begin
                p0_gnt = pick[0];
                p1_gnt = pick[1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_q;
        owner_d = OWNER_NONE;

        // Burst ends as soon as port 1 stops asking for it.
        if (state_q == ARB_STATE_BURST1 && !(p1_req && p1_lock)) begin
            state_d = ARB_STATE_RR;
            burst_d = 8'd0;
        end

        if (p0_gnt) begin
            last_d  = 1'b0;
            state_d = ARB_STATE_RR;
            burst_d = 8'd0;
            if (is_read(p0_we)) begin
                owner_d = OWNER_P0;
            end
        end else if (p1_gnt) begin
            last_d = 1'b1;
            if (is_read(p1_we)) begin
                owner_d = OWNER_P1;
            end
            if (p1_lock && (burst_inc < BURST_LIM)) begin
                state_d = ARB_STATE_BURST1;
                burst_d = burst_inc;
            end else begin
                // Unlocked access or burst limit: back to RR, port 0 favoured.
                state_d = ARB_STATE_RR;
                burst_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_STATE_RR;
            owner_q <= OWNER_NONE;
            last_q  <= 1'b1;
            burst_q <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        mem_we   = 4'b0000;
        mem_addr = '0;
        mem_din  = '0;
        if (p0_gnt) begin
            mem_we   = p0_we;
            mem_addr = p0_addr;
            mem_din  = p0_wdata;
        end else if (p1_gnt) begin
            mem_we   = p1_we;
            mem_addr = p1_addr;
            mem_din  = p1_wdata;
        end
    end

    assign mem_en = p0_gnt | p1_gnt;
    assign stall  = p0_req & ~p0_gnt;

    // A read granted just before reset must not return data during reset.
    assign p0_rvalid = !rst && (owner_q == OWNER_P0);
    assign p1_rvalid = !rst && (owner_q == OWNER_P1);
    assign p0_rdata  = p0_rvalid ? mem_dout : '0;
    assign p1_rdata  = p1_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW        = 14;
    localparam int DW        = 32;
    localparam int MAX_BURST = 8;
    localparam int MAX_WAIT  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p1_req = 1'b0, p1_lock = 1'b0;
    logic [3:0]    p0_we = '0, p1_we = '0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, stall;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;

    dmem_arbiter #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .MAX_BURST (MAX_BURST),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_lock   (p1_lock),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    // Memory seen by the DUT.
    logic [31:0] mem_arr [0:63];
    // Reference copy of memory, updated from the requesters' own transactions.
    logic [31:0] shadow  [0:63];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = init_word(i);
            shadow[i]  = init_word(i);
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_dout <= mem_arr[mem_addr[5:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) mem_arr[mem_addr[5:0]][8*b +: 8] <= mem_din[8*b +: 8];
                end
            end
        end
    end

    int unsigned cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    // Reference arbitration state.
    bit m_favour_p0 = 1'b1;
    bit m_burst_on  = 1'b0;
    int m_burst_n   = 0;
    int m_wait      = 0;

    logic g0_prev = 1'b0, g1_prev = 1'b0;
    bit   phase_c = 1'b0;
    int   run = 0, max_run = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Grant checker and reference model.
    initial forever begin
        bit e0, e1;
        @(negedge clk);
        e0 = 1'b0;
        e1 = 1'b0;
        if (!rst) begin
            if (m_burst_on && p1_req && p1_lock) begin
                e1 = 1'b1;
            end else begin
`ifdef CORE_PRIORITY_EN
                if (p1_req && (m_wait == MAX_WAIT || !p0_req)) e1 = 1'b1;
                else if (p0_req) e0 = 1'b1;
`else
                if (p0_req && p1_req) begin
                    if (m_favour_p0) e0 = 1'b1;
                    else e1 = 1'b1;
                end else begin
                    e0 = p0_req;
                    e1 = p1_req;
                end
`endif
            end
        end
        check("p0_gnt", 32'(p0_gnt), 32'(e0));
        check("p1_gnt", 32'(p1_gnt), 32'(e1));
        check("stall", 32'(stall), 32'(p0_req && !e0));
        check("mem_en", 32'(mem_en), 32'(e0 || e1));
        if (e0) begin
            check("mem_we_p0", 32'(mem_we), 32'(p0_we));
            check("mem_addr_p0", 32'(mem_addr), 32'(p0_addr));
            check("mem_din_p0", mem_din, p0_wdata);
            if (p0_we == 4'b0) q0.push_back('{shadow[p0_addr[5:0]], cyc + 1});
            else shadow[p0_addr[5:0]] = merge(shadow[p0_addr[5:0]], p0_we, p0_wdata);
        end else if (e1) begin
            check("mem_we_p1", 32'(mem_we), 32'(p1_we));
            check("mem_addr_p1", 32'(mem_addr), 32'(p1_addr));
            check("mem_din_p1", mem_din, p1_wdata);
            if (p1_we == 4'b0) q1.push_back('{shadow[p1_addr[5:0]], cyc + 1});
            else shadow[p1_addr[5:0]] = merge(shadow[p1_addr[5:0]], p1_we, p1_wdata);
        end else begin
            check("mem_idle", {mem_din[27:0] != 0, mem_we, mem_addr[AW-1:0] != 0, 11'd0}, 32'd0);
        end

        if (rst) begin
            m_favour_p0 = 1'b1;
            m_burst_on  = 1'b0;
            m_burst_n   = 0;
            m_wait      = 0;
        end else begin
            if (m_burst_on && !(p1_req && p1_lock)) begin
                m_burst_on = 1'b0;
                m_burst_n  = 0;
            end
            if (e0) begin
                m_favour_p0 = 1'b0;
                m_burst_on  = 1'b0;
                m_burst_n   = 0;
            end else if (e1) begin
                m_favour_p0 = 1'b1;
                if (p1_lock) begin
                    m_burst_n++;
                    m_burst_on = (m_burst_n < MAX_BURST);
                    if (!m_burst_on) m_burst_n = 0;
                end else begin
                    m_burst_on = 1'b0;
                    m_burst_n  = 0;
                end
            end
            m_wait = (p1_req && !e1) ? m_wait + 1 : 0;
        end

        if (phase_c) begin
            run = p1_gnt ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        g0_prev = p0_gnt;
        g1_prev = p1_gnt;
    end

    // Read-return monitor.
    initial forever begin
        bit          v0, v1;
        logic [31:0] d0, d1;
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        if (rst) begin
            while (q0.size() > 0 && q0[0].due <= cyc) void'(q0.pop_front());
            while (q1.size() > 0 && q1[0].due <= cyc) void'(q1.pop_front());
        end else begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
                v0 = 1'b1;
                d0 = q0.pop_front().data;
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                v1 = 1'b1;
                d1 = q1.pop_front().data;
            end
        end
        check("p0_rvalid", 32'(p0_rvalid), 32'(v0));
        check("p0_rdata", p0_rdata, d0);
        check("p1_rvalid", 32'(p1_rvalid), 32'(v1));
        check("p1_rdata", p1_rdata, d1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_we();
        return ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    endfunction

    // Issue a new transaction on a port unless it is still waiting for a grant.
    task automatic drive(input bit port, input bit req, input logic [3:0] we, input int addr,
                         input logic [31:0] data);
        if (port == 1'b0) begin
            if (!(p0_req && !g0_prev)) begin
                p0_req = req; p0_we = we; p0_addr = AW'(addr); p0_wdata = data;
            end
        end else begin
            if (!(p1_req && !g1_prev)) begin
                p1_req = req; p1_we = we; p1_addr = AW'(addr); p1_wdata = data;
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive(1'b0, 1'b0, 4'b0, 0, 0);
            drive(1'b1, 1'b0, 4'b0, 0, 0);
            tick();
            done = !p0_req && !p1_req;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic p0_xfer(input logic [3:0] we, input int addr, input logic [31:0] data);
        bit got;
        got = 1'b0;
        p0_req = 1'b1; p0_we = we; p0_addr = AW'(addr); p0_wdata = data;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = p0_gnt;
        end
        if (!got) check("p0_xfer_timeout", 32'd0, 32'd1);
        tick();
        p0_req = 1'b0;
    endtask

    initial begin
        bit got;
        repeat (3) tick();
        rst = 1'b0;

        // Port 0 alone reads the 0xDEADBEEF word a few times.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 4'b0000, 16, 0);
            tick();
        end
        drain();

        // Both ports request every cycle, no lock.
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b1, rand_we(), $urandom_range(0, 63), $urandom);
            drive(1'b1, 1'b1, rand_we(), $urandom_range(0, 63), $urandom);
            tick();
        end
        drain();

        // Locked port 1 write stream against a continuously requesting port 0.
        p1_lock = 1'b1;
        run = 0;
        max_run = 0;
        phase_c = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b1, rand_we(), $urandom_range(0, 63), $urandom);
            drive(1'b1, 1'b1, 4'b1111, $urandom_range(0, 63), $urandom);
            tick();
        end
        phase_c = 1'b0;
        p1_lock = 1'b0;
        check("burst_len", 32'(max_run), 32'(MAX_BURST));
        drain();

        // Reset right after a port 1 read grant.
        p1_req = 1'b1; p1_we = 4'b0; p1_addr = AW'(5);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = g1_prev;
        end
        if (!got) check("p1_read_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 4'b0; p0_addr = AW'(7);
        tick();
        tick();
        rst = 1'b0;
        p1_req = 1'b1; p1_we = 4'b0; p1_addr = AW'(8);
        @(negedge clk);
        check("tie_after_rst_p0", 32'(p0_gnt), 32'd1);
        check("tie_after_rst_p1", 32'(p1_gnt), 32'd0);
        tick();
        drain();

        // Byte write then read back the merged word.
        p0_xfer(4'b0010, 3, 32'h0000AB00);
        p0_xfer(4'b0000, 3, 32'h0);
        drain();

        // Random traffic with lock stretches.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) p1_lock = ~p1_lock;
            drive(1'b0, $urandom_range(0, 3) != 0, rand_we(), $urandom_range(0, 63), $urandom);
            drive(1'b1, $urandom_range(0, 1) != 0, rand_we(), $urandom_range(0, 63), $urandom);
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            else rst = 1'b0;
            tick();
        end
        rst = 1'b0;
        p1_lock = 1'b0;
        drain();
        repeat (3) tick();
        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
